// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - Frames a snapshot of 32-bit status words as HEADER, LEN, payload, XOR checksum into the UART TX queue.
module uart_tx_framer #(
    parameter int         NUM_WORDS = 8,
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int         IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_send,
    input  logic [NUM_WORDS-1:0][31:0] i_words,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_enq_txq,
    output logic [7:0]                 o_txq_data,
    input  logic                       i_txq_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [7:0]           LEN_BYTE = 8'(NUM_WORDS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    state_t                     r_state;
    logic [NUM_WORDS-1:0][31:0] r_snap;
    logic [IDX_WIDTH-1:0]       r_word_idx;
    logic [1:0]                 r_byte_idx;
    logic [7:0]                 r_csum;

    logic                       w_emit;
    logic                       w_enq;
    logic [31:0]                w_word;
    logic [7:0]                 w_data_byte;
    logic [7:0]                 w_data;

    assign w_emit = (r_state == S_HDR) || (r_state == S_LEN) ||
                    (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_enq  = w_emit && !i_txq_full;
    assign w_word = r_snap[r_word_idx];

    // Payload goes out MSB-first within each word to match the receive-side assembler.
    always_comb begin
        w_data_byte = 8'h00;
        case (r_byte_idx)
            2'd0: w_data_byte = w_word[31:24];
            2'd1: w_data_byte = w_word[23:16];
            2'd2: w_data_byte = w_word[15:8];
            2'd3: w_data_byte = w_word[7:0];
            default: w_data_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_data = 8'h00;
        case (r_state)
            S_HDR:  w_data = HEADER;
            S_LEN:  w_data = LEN_BYTE;
            S_DATA: w_data = w_data_byte;
            S_CSUM: w_data = r_csum;
            default: w_data = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_snap     <= '0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_send) begin
                        r_snap     <= i_words;
                        r_word_idx <= '0;
                        r_byte_idx <= 2'd0;
                        r_csum     <= 8'h00;
                        r_state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_enq) begin
                        r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_enq) begin
                        r_csum  <= r_csum ^ LEN_BYTE;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    // Everything holds while the FIFO is full so no byte is skipped or repeated.
                    if (w_enq) begin
                        r_csum     <= r_csum ^ w_data_byte;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            if (r_word_idx == LAST_IDX) begin
                                r_state <= S_CSUM;
                            end else begin
                                r_word_idx <= r_word_idx + 1'b1;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (w_enq) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_enq_txq  = w_enq;
    assign o_txq_data = w_data;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - Scoreboard bench for uart_tx_framer with 2-word and 1-word instances.
module tb_uart_tx_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             send2, full2, busy2, done2, enq2;
    logic [1:0][31:0] words2;
    logic [7:0]       data2;
    logic             send1, full1, busy1, done1, enq1;
    logic [0:0][31:0] words1;
    logic [7:0]       data1;

    uart_tx_framer #(.NUM_WORDS(2), .HEADER(8'hA5)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_send(send2), .i_words(words2),
        .o_busy(busy2), .o_done(done2), .o_enq_txq(enq2), .o_txq_data(data2),
        .i_txq_full(full2)
    );

    uart_tx_framer #(.NUM_WORDS(1), .HEADER(8'hA5)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_send(send1), .i_words(words1),
        .o_busy(busy1), .o_done(done1), .o_enq_txq(enq1), .o_txq_data(data1),
        .i_txq_full(full1)
    );

    int         cyc = 0;
    logic [7:0] exp2[$], got2[$], exp1[$], got1[$];
    int         gcyc2[$];
    int         busy_cnt2, done_cnt2, done_cyc2, busy_cnt1, done_cnt1;
    int         send_cyc;
    int         vectors = 0;
    int         miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (enq2) begin
            got2.push_back(data2);
            gcyc2.push_back(cyc);
        end
        if (busy2) busy_cnt2++;
        if (done2) begin
            done_cnt2++;
            done_cyc2 = cyc;
        end
        if (enq1) got1.push_back(data1);
        if (busy1) busy_cnt1++;
        if (done1) done_cnt1++;
    end

    function automatic void model(input int dut, input int n, input logic [31:0] w0, input logic [31:0] w1);
        logic [7:0]  q[$];
        logic [7:0]  cs;
        logic [7:0]  by;
        logic [31:0] w;
        q.push_back(8'hA5);
        q.push_back(8'(n));
        cs = 8'(n);
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? w0 : w1;
            for (int b = 0; b < 4; b++) begin
                by = w[31-8*b -: 8];
                q.push_back(by);
                cs = cs ^ by;
            end
        end
        q.push_back(cs);
        foreach (q[i]) begin
            if (dut == 2) exp2.push_back(q[i]);
            else          exp1.push_back(q[i]);
        end
    endfunction

    task automatic clear_mon();
        exp2.delete(); got2.delete(); gcyc2.delete();
        exp1.delete(); got1.delete();
        busy_cnt2 = 0; done_cnt2 = 0; done_cyc2 = -1;
        busy_cnt1 = 0; done_cnt1 = 0;
    endtask

    task automatic pulse_send(input int dut);
        @(posedge clk); #1;
        send_cyc = cyc;
        if (dut == 2) send2 = 1'b1; else send1 = 1'b1;
        @(posedge clk); #1;
        send2 = 1'b0;
        send1 = 1'b0;
    endtask

    task automatic wait_done(input int dut, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((dut == 2) ? done2 : done1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy2); end
        vectors++; if (done2 !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done2); end
        vectors++; if (enq2 !== 1'b0) begin miscompares++; $display("FAIL reset_enq got=%b exp=0", enq2); end
        vectors++; if (data2 !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%02h exp=00", data2); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit         ok;
        logic [7:0] e, g;
        clear_mon();
        words2 = {32'hA0B0C0D0, 32'h01020304};
        model(2, 2, 32'h01020304, 32'hA0B0C0D0);
        pulse_send(2);
        wait_done(2, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout got=no_done exp=done"); end
        vectors++; if (got2.size() != exp2.size()) begin miscompares++; $display("FAIL basic_count got=%0d exp=%0d", got2.size(), exp2.size()); end
        vectors++; if (gcyc2.size() > 0 && gcyc2[0] != send_cyc + 1) begin miscompares++; $display("FAIL basic_latency got=%0d exp=%0d", gcyc2[0], send_cyc + 1); end
        vectors++; if (gcyc2.size() > 0 && done_cyc2 != gcyc2[gcyc2.size()-1] + 1) begin miscompares++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc2, gcyc2[gcyc2.size()-1] + 1); end
        vectors++; if (busy_cnt2 != 12) begin miscompares++; $display("FAIL basic_busy_cycles got=%0d exp=12", busy_cnt2); end
        vectors++; if (done_cnt2 != 1) begin miscompares++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt2); end
        for (int i = 0; exp2.size() > 0 && got2.size() > 0; i++) begin
            e = exp2.pop_front(); g = got2.pop_front();
            vectors++; if (g !== e) begin miscompares++; $display("FAIL basic_byte%0d got=%02h exp=%02h", i, g, e); end
        end
    endtask

    task automatic test_backpressure();
        bit         ok;
        bit         found;
        logic [7:0] e, g;
        clear_mon();
        words2 = {32'hA0B0C0D0, 32'h01020304};
        model(2, 2, 32'h01020304, 32'hA0B0C0D0);
        pulse_send(2);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (enq2 && data2 == 8'h03) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL bp_find03 got=absent exp=present"); end
        full2 = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            vectors++; if (enq2 !== 1'b0) begin miscompares++; $display("FAIL bp_stall%0d_enq got=%b exp=0", s, enq2); end
            vectors++; if (data2 !== 8'h03) begin miscompares++; $display("FAIL bp_stall%0d_data got=%02h exp=03", s, data2); end
            @(posedge clk); #1;
        end
        full2 = 1'b0;
        wait_done(2, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_timeout got=no_done exp=done"); end
        vectors++; if (got2.size() != exp2.size()) begin miscompares++; $display("FAIL bp_count got=%0d exp=%0d", got2.size(), exp2.size()); end
        vectors++; if (busy_cnt2 != 17) begin miscompares++; $display("FAIL bp_busy_cycles got=%0d exp=17", busy_cnt2); end
        for (int i = 0; exp2.size() > 0 && got2.size() > 0; i++) begin
            e = exp2.pop_front(); g = got2.pop_front();
            vectors++; if (g !== e) begin miscompares++; $display("FAIL bp_byte%0d got=%02h exp=%02h", i, g, e); end
        end
    endtask

    task automatic test_snapshot();
        bit         ok;
        logic [7:0] e, g;
        clear_mon();
        words2 = {32'hA0B0C0D0, 32'h01020304};
        model(2, 2, 32'h01020304, 32'hA0B0C0D0);
        pulse_send(2);
        repeat (3) @(posedge clk); #1;
        words2 = '1;
        send2 = 1'b1;
        @(posedge clk); #1;
        send2 = 1'b0;
        wait_done(2, 100, ok);
        repeat (10) @(posedge clk); #1;
        vectors++; if (!ok) begin miscompares++; $display("FAIL snap_timeout got=no_done exp=done"); end
        vectors++; if (done_cnt2 != 1) begin miscompares++; $display("FAIL snap_done_pulses got=%0d exp=1", done_cnt2); end
        vectors++; if (got2.size() != exp2.size()) begin miscompares++; $display("FAIL snap_count got=%0d exp=%0d", got2.size(), exp2.size()); end
        for (int i = 0; exp2.size() > 0 && got2.size() > 0; i++) begin
            e = exp2.pop_front(); g = got2.pop_front();
            vectors++; if (g !== e) begin miscompares++; $display("FAIL snap_byte%0d got=%02h exp=%02h", i, g, e); end
        end
    endtask

    task automatic test_reset_midframe();
        bit         ok;
        bit         found;
        logic [7:0] e, g;
        clear_mon();
        words2 = {32'hA0B0C0D0, 32'h01020304};
        model(2, 2, 32'h01020304, 32'hA0B0C0D0);
        pulse_send(2);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (got2.size() >= 4) begin found = 1'b1; break; end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL rstmid_reach got=%0d exp=4", got2.size()); end
        rst = 1'b1;
        #1;
        vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL rstmid_async_busy got=%b exp=0", busy2); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        vectors++; if (got2.size() != 4) begin miscompares++; $display("FAIL rstmid_no_enq got=%0d exp=4", got2.size()); end
        vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", busy2); end
        for (int i = 0; i < 4 && got2.size() > 0; i++) begin
            e = exp2.pop_front(); g = got2.pop_front();
            vectors++; if (g !== e) begin miscompares++; $display("FAIL rstmid_byte%0d got=%02h exp=%02h", i, g, e); end
        end
        clear_mon();
        model(2, 2, 32'h01020304, 32'hA0B0C0D0);
        pulse_send(2);
        wait_done(2, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_fresh_timeout got=no_done exp=done"); end
        vectors++; if (got2.size() != exp2.size()) begin miscompares++; $display("FAIL rstmid_fresh_count got=%0d exp=%0d", got2.size(), exp2.size()); end
        for (int i = 0; exp2.size() > 0 && got2.size() > 0; i++) begin
            e = exp2.pop_front(); g = got2.pop_front();
            vectors++; if (g !== e) begin miscompares++; $display("FAIL rstmid_fresh_byte%0d got=%02h exp=%02h", i, g, e); end
        end
    endtask

    task automatic test_one_word();
        bit         ok;
        logic [7:0] e, g;
        clear_mon();
        words1 = 32'hDEADBEEF;
        model(1, 1, 32'hDEADBEEF, 32'h0);
        pulse_send(1);
        wait_done(1, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL one_timeout got=no_done exp=done"); end
        vectors++; if (got1.size() != exp1.size()) begin miscompares++; $display("FAIL one_count got=%0d exp=%0d", got1.size(), exp1.size()); end
        vectors++; if (busy_cnt1 != 8) begin miscompares++; $display("FAIL one_busy_cycles got=%0d exp=8", busy_cnt1); end
        vectors++; if (done_cnt1 != 1) begin miscompares++; $display("FAIL one_done_pulses got=%0d exp=1", done_cnt1); end
        for (int i = 0; exp1.size() > 0 && got1.size() > 0; i++) begin
            e = exp1.pop_front(); g = got1.pop_front();
            vectors++; if (g !== e) begin miscompares++; $display("FAIL one_byte%0d got=%02h exp=%02h", i, g, e); end
        end
    endtask

    task automatic test_back_to_back();
        bit         ok;
        logic [7:0] e, g;
        clear_mon();
        words2 = {32'h55AA33CC, 32'h89ABCDEF};
        for (int f = 0; f < 3; f++) model(2, 2, 32'h89ABCDEF, 32'h55AA33CC);
        @(posedge clk); #1;
        send2 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (done_cnt2 >= 3) begin ok = 1'b1; break; end
        end
        send2 = 1'b0;
        repeat (10) @(posedge clk); #1;
        vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_timeout got=%0d exp=3", done_cnt2); end
        vectors++; if (done_cnt2 != 3) begin miscompares++; $display("FAIL b2b_done_pulses got=%0d exp=3", done_cnt2); end
        vectors++; if (got2.size() != exp2.size()) begin miscompares++; $display("FAIL b2b_count got=%0d exp=%0d", got2.size(), exp2.size()); end
        if (gcyc2.size() >= 23) begin
            vectors++; if (gcyc2[10] - gcyc2[0] != 10) begin miscompares++; $display("FAIL b2b_frame0_span got=%0d exp=10", gcyc2[10] - gcyc2[0]); end
            vectors++; if (gcyc2[11] - gcyc2[10] != 3) begin miscompares++; $display("FAIL b2b_gap1 got=%0d exp=3", gcyc2[11] - gcyc2[10]); end
            vectors++; if (gcyc2[22] - gcyc2[21] != 3) begin miscompares++; $display("FAIL b2b_gap2 got=%0d exp=3", gcyc2[22] - gcyc2[21]); end
        end
        for (int i = 0; exp2.size() > 0 && got2.size() > 0; i++) begin
            e = exp2.pop_front(); g = got2.pop_front();
            vectors++; if (g !== e) begin miscompares++; $display("FAIL b2b_byte%0d got=%02h exp=%02h", i, g, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        send2  = 1'b0; full2 = 1'b0; words2 = '0;
        send1  = 1'b0; full1 = 1'b0; words1 = '0;
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_reset_midframe();
        test_one_word();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Transmit-side counterpart of the UART command path: snapshots a block of 32-bit status/readback words and serializes it as a framed byte stream into the UART TX queue.
- Byte order is MSB-first per word, matching the receive-side word assembler.
- Sits between status sources (DC armed flags, launch state, register readback) and the UART TX FIFO enqueue interface.
- Frame format: HEADER byte, length byte, 4*NUM_WORDS payload bytes, XOR checksum byte.

Parameters:
- NUM_WORDS, 8, number of 32-bit words per frame; legal range 1..255.
- HEADER, 8'hA5, first byte of every frame.
- IDX_WIDTH, $clog2(NUM_WORDS) (minimum 1), width of the word index counter.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_send  input  1  frame request; sampled only in IDLE.
- i_words  input  [NUM_WORDS-1:0][31:0]  payload words; word 0 is sent first.
- o_busy  output  1  high from the cycle after an accepted i_send until DONE exits.
- o_done  output  1  one-cycle pulse after the checksum byte is enqueued.
- o_enq_txq  output  1  enqueue strobe to the UART TX FIFO.
- o_txq_data  output  8  byte to enqueue; valid when o_enq_txq=1.
- i_txq_full  input  1  TX FIFO full; blocks enqueue.

Behaviour:
- Reset (async assert, i_rst=1): state=IDLE; snapshot, counters and checksum cleared; o_busy=0, o_done=0, o_enq_txq=0, o_txq_data=0. Reset mid-frame aborts immediately; no further bytes are emitted after deassert.
- States: IDLE, HDR, LEN, DATA, CSUM, DONE.
- IDLE: if i_send=1, latch i_words into the snapshot register, clear the checksum and word/byte counters, then go to HDR. Later changes to i_words do not affect the frame in flight.
- Emit states (HDR, LEN, DATA, CSUM):
  - o_enq_txq = !i_txq_full (combinational).
  - The state or counter advances only on a cycle with o_enq_txq=1. While i_txq_full=1 the state, counters and o_txq_data hold.
- HDR: o_txq_data=HEADER; then LEN.
- LEN: o_txq_data=NUM_WORDS[7:0]; checksum ^= byte; then DATA.
- DATA: o_txq_data = snapshot[word_idx][31-8*byte_idx -: 8]; checksum ^= byte.
  - byte_idx counts 0..3, then wraps to 0 and word_idx increments.
  - On byte_idx=3 with word_idx=NUM_WORDS-1, go to CSUM.
- CSUM: o_txq_data = running checksum (XOR of the LEN byte and all payload bytes; HEADER excluded); then DONE.
- DONE: o_done=1 for exactly one cycle; return to IDLE.
- o_busy = (state != IDLE).
- i_send while not in IDLE is ignored; it is not queued.
- i_send asserted in the IDLE cycle that follows DONE is accepted, so back-to-back frames are allowed.
- Latency: i_send in cycle 0 → header enqueued in cycle 1 if the FIFO is not full.
- Minimum frame duration with no backpressure: 4*NUM_WORDS+3 enqueue cycles, plus 1 DONE cycle, plus 1 IDLE cycle.
- Exactly one byte is enqueued per o_enq_txq pulse. Bytes are never duplicated or dropped across backpressure stalls.
- Checksum register is 8 bits, XOR only; no carry.

Test Plan:
- NUM_WORDS=2, words {32'h01020304, 32'hA0B0C0D0}, i_txq_full=0, pulse i_send → enqueued bytes exactly A5 02 01 02 03 04 A0 B0 C0 D0 06; o_done pulses one cycle after the 06 byte; o_busy spans 12 cycles.
- Same frame, i_txq_full=1 for 5 cycles starting at the payload byte 03 → o_enq_txq=0 and o_txq_data held at 03 during the stall; the byte sequence is identical to the first test.
- Change i_words to all-FF and pulse i_send mid-frame → frame content is unchanged, no second frame starts, and exactly one o_done pulse occurs.
- Assert i_rst after byte 02 of the payload, release, wait 10 cycles → no enqueue after reset; o_busy=0; a fresh i_send produces the full correct frame from A5.
- NUM_WORDS=1, word 32'hDEADBEEF → bytes A5 01 DE AD BE EF 23; word_idx never increments.
- Hold i_send=1 continuously → frames are emitted back to back, separated by exactly one DONE cycle and one IDLE cycle; every frame's checksum is correct.
